sop_trig_lane_array: RTL

//  Parametrised successor of the single-output registered AND-OR benchmark subcircuit.

---
 rtl/sop_trig_pkg.sv | 30 +++
 rtl/sop_lane.sv | 56 +++++
 rtl/sop_trig_lane_array.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sop_trig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sop_trig_pkg
// Purpose  : Shared trigger FSM state type, default pattern constants and
//            the match-counter width helper for sop_trig_lane_array.
// Revision : 1.0  initial release
// ============================================================================
package sop_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HIT   = 2'd2
    } trig_state_t;

    localparam int         c_DEF_TRIG_LEN = 3;
    localparam logic [3:0] c_DEF_TRIG_PAT = 4'b1010;

    // Bits needed to hold 0..len inclusive, i.e. ceil(log2(len+1)), min 1.
    function automatic int clog2_len(input int len);
        int w;
        w = 1;
        while ((2 ** w) < (len + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sop_lane.sv
`default_nettype none
// ============================================================================
// Module   : sop_lane
// Purpose  : One lane: stage-1 input capture, AND-OR evaluation, output reg.
// Revision : 1.0  initial release
// ============================================================================
module sop_lane (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cap_i,
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic x_i,
    input  logic y_i,
    input  logic en_i,
    output logic sop_o
);

    logic a_q, b_q, c_q, x_q, y_q, en_q;
    logic sop_q;
    logic sop_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q  <= 1'b0;
            b_q  <= 1'b0;
            c_q  <= 1'b0;
            x_q  <= 1'b0;
            y_q  <= 1'b0;
            en_q <= 1'b0;
        end else if (cap_i) begin
            a_q  <= a_i;
            b_q  <= b_i;
            c_q  <= c_i;
            x_q  <= x_i;
            y_q  <= y_i;
            en_q <= en_i;
        end
    end

    assign sop_d = (a_q & en_q) | (~(x_q | y_q) & ~b_q & c_q);

    // Output stage re-evaluates every cycle; freshness is tracked at the top.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sop_q <= 1'b0;
        end else begin
            sop_q <= sop_d;
        end
    end

    assign sop_o = sop_q;

endmodule
`default_nettype wire

// File: rtl/sop_trig_lane_array.sv
`default_nettype none
// ============================================================================
// Module   : sop_trig_lane_array
// Purpose  : LANES registered AND-OR lanes plus a pattern trigger FSM.
//            Optional activity counter enabled by macro SOP_ACT_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module sop_trig_lane_array
    import sop_trig_pkg::*;
#(
    parameter int               LANES    = 4,
    parameter int               TRIG_LEN = c_DEF_TRIG_LEN,
    parameter logic [LANES-1:0] TRIG_PAT = LANES'(c_DEF_TRIG_PAT),
    parameter int               CNT_W    = 8
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             in_valid,
    input  logic [LANES-1:0] d_a,
    input  logic [LANES-1:0] d_b,
    input  logic [LANES-1:0] d_c,
    input  logic [LANES-1:0] g_x,
    input  logic [LANES-1:0] g_y,
    input  logic [LANES-1:0] g_en,
    input  logic             trig_clr,
    output logic [LANES-1:0] out_sop,
    output logic             out_valid,
    output logic             trig_hit,
    output logic [CNT_W-1:0] act_cnt
);

    localparam int              c_CW  = clog2_len(TRIG_LEN);
    localparam logic [c_CW-1:0] c_LEN = c_CW'(TRIG_LEN);

    logic [LANES-1:0] w_sop;
    logic             valid1_q;
    logic             valid_q;
    logic             w_match;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sop_lane u_lane (
            .clk_i (I1470_clk),
            .rst_i (I1477_rst),
            .cap_i (in_valid),
            .a_i   (d_a[i]),
            .b_i   (d_b[i]),
            .c_i   (d_c[i]),
            .x_i   (g_x[i]),
            .y_i   (g_y[i]),
            .en_i  (g_en[i]),
            .sop_o (w_sop[i])
        );
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            valid1_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid1_q <= in_valid;
            valid_q  <= valid1_q;
        end
    end

    assign out_sop   = w_sop;
    assign out_valid = valid_q;
    assign w_match   = valid_q & (w_sop == TRIG_PAT);

    trig_state_t     state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [c_CW-1:0] w_cnt_inc;
    logic            hit_q, hit_d;

    assign w_cnt_inc = cnt_q + c_CW'(1);

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // Clear wins over any match seen in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        if (trig_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            hit_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_match) begin
                        cnt_d = c_CW'(1);
                        if (c_LEN == c_CW'(1)) begin
                            state_d = HIT;
                            hit_d   = 1'b1;
                        end else begin
                            state_d = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (w_match) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_LEN) begin
                            state_d = HIT;
                            hit_d   = 1'b1;
                        end
                    end else if (valid_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HIT: begin
                    hit_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                end
            endcase
        end
    end

    assign trig_hit = hit_q;

`ifdef SOP_ACT_CNT_EN
    logic [CNT_W-1:0] act_q;

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst || trig_clr) begin
            act_q <= '0;
        end else if (valid_q && (|w_sop) && (act_q != {CNT_W{1'b1}})) begin
            act_q <= act_q + CNT_W'(1);
        end
    end

    assign act_cnt = act_q;
`else
    assign act_cnt = '0;
`endif

endmodule
`default_nettype wire
